siteswap_decoder: RTL and testbench

Recovers the siteswap pattern from per-ball trajectory samples: the inverse of pattern-to-trajectory generation. Sits downstream of trajectory_generator, or of a ball tracker feeding the same x/y sample format. Tracks when each ball leaves and returns to hand level, measures its flight time in beats, and rebuilds the throw-height sequence. Its output is used for loopback self-check and for display.

---
 rtl/siteswap_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_siteswap_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siteswap_decoder.sv
// siteswap_decoder: rebuilds siteswap throw heights from per-ball y trajectories.
// Optional consistency checking is compiled in when SITESWAP_CHECK_EN is defined.
module siteswap_decoder #(
    parameter int MAX_HEIGHT = 7
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [6:0][10:0] traj_x_in,
    input  logic [6:0][9:0]  traj_y_in,
    input  logic             traj_valid_in,
    input  logic [2:0]       num_balls,
    input  logic [2:0]       period_in,
    input  logic [9:0]       hand_y_in,
    input  logic [31:0]      cyc_per_beat,
    output logic [6:0][2:0]  pattern_out,
    output logic             pattern_valid_out,
    output logic             throw_valid_out,
    output logic [2:0]       throw_ball_out,
    output logic [2:0]       throw_height_out,
    output logic             error_out,
    output logic             mismatch_out,
    output logic [1:0]       fsm_state
);

    localparam logic [2:0] MAX_H = 3'(MAX_HEIGHT);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2} state_t;
    state_t state, state_nxt;

    logic [6:0][9:0]  prev_y;
    logic [6:0]       air;
    logic [6:0][31:0] cyc_cnt;
    logic [6:0][2:0]  beat_cnt;
    logic [6:0]       ovf;
    logic [6:0][2:0]  ord;
    logic [2:0]       seq;
    logic [2:0]       nb_q, per_q;

    logic [6:0]       land_q, land_sat_q;
    logic [6:0][2:0]  land_h_q, land_slot_q;
    logic [6:0]       filled;
    logic [6:0]       slot_mask;

    logic [2:0]       per_eff;
    logic             restart;
    logic             active_sample;

    logic             unused_x;
    assign unused_x = ^traj_x_in;

    assign per_eff       = (period_in == 3'd0) ? 3'd1 : period_in;
    assign restart       = (state == TRACK) && ((num_balls != nb_q) || (period_in != per_q));
    assign active_sample = traj_valid_in && (state == TRACK) && !restart;
    assign fsm_state     = state;

    always_comb begin
        for (int k = 0; k < 7; k++) slot_mask[k] = (3'(k) < per_eff);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (traj_valid_in) state_nxt = TRACK;
            TRACK:   if (restart) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration shadow used only to spot a change while tracking.
    always_ff @(posedge clk_in) begin
        nb_q  <= num_balls;
        per_q <= period_in;
    end

    logic [6:0]       air_nxt, ovf_nxt, land_det, land_sat;
    logic [6:0][31:0] cyc_nxt;
    logic [6:0][2:0]  beat_nxt, ord_nxt, land_h;
    logic [2:0]       seq_nxt;
    logic [3:0]       h_raw;

    // Counting includes the landing sample itself, so height uses post-increment counts.
    always_comb begin
        air_nxt  = air;
        ovf_nxt  = ovf;
        cyc_nxt  = cyc_cnt;
        beat_nxt = beat_cnt;
        ord_nxt  = ord;
        seq_nxt  = seq;
        land_det = '0;
        land_sat = '0;
        land_h   = '0;
        h_raw    = '0;
        for (int i = 0; i < 7; i++) begin
            if (active_sample && (3'(i) < num_balls)) begin
                if (air[i]) begin
                    if (cyc_cnt[i] + 32'd1 == cyc_per_beat) begin
                        cyc_nxt[i] = '0;
                        if (beat_cnt[i] == MAX_H) ovf_nxt[i]  = 1'b1;
                        else                      beat_nxt[i] = beat_cnt[i] + 3'd1;
                    end else begin
                        cyc_nxt[i] = cyc_cnt[i] + 32'd1;
                    end
                    if (traj_y_in[i] >= hand_y_in) begin
                        air_nxt[i]  = 1'b0;
                        land_det[i] = 1'b1;
                        h_raw = {1'b0, beat_nxt[i]} +
                                ((cyc_nxt[i] >= (cyc_per_beat >> 1)) ? 4'd1 : 4'd0);
                        if (ovf_nxt[i] || (h_raw > {1'b0, MAX_H})) begin
                            land_h[i]   = MAX_H;
                            land_sat[i] = 1'b1;
                        end else begin
                            land_h[i] = h_raw[2:0];
                        end
                    end
                end else if ((prev_y[i] >= hand_y_in) && (traj_y_in[i] < hand_y_in)) begin
                    air_nxt[i]  = 1'b1;
                    cyc_nxt[i]  = '0;
                    beat_nxt[i] = '0;
                    ovf_nxt[i]  = 1'b0;
                    ord_nxt[i]  = seq_nxt;
                    seq_nxt     = (seq_nxt + 3'd1 == per_eff) ? 3'd0 : seq_nxt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            prev_y      <= '0;
            air         <= '0;
            cyc_cnt     <= '0;
            beat_cnt    <= '0;
            ovf         <= '0;
            ord         <= '0;
            seq         <= '0;
            land_q      <= '0;
            land_sat_q  <= '0;
            land_h_q    <= '0;
            land_slot_q <= '0;
        end else begin
            if (traj_valid_in) prev_y <= traj_y_in;
            if (restart) begin
                air    <= '0;
                seq    <= '0;
                land_q <= '0;
            end else if (active_sample) begin
                air         <= air_nxt;
                cyc_cnt     <= cyc_nxt;
                beat_cnt    <= beat_nxt;
                ovf         <= ovf_nxt;
                ord         <= ord_nxt;
                seq         <= seq_nxt;
                land_q      <= land_det;
                land_sat_q  <= land_sat;
                land_h_q    <= land_h;
                land_slot_q <= ord;
            end else begin
                land_q <= '0;
            end
        end
    end

    logic [6:0][2:0] pat_nxt;
    logic [6:0]      filled_nxt;
    logic            pulse, err_set;
    logic [2:0]      rep_ball, rep_h;

    // Descending scan: the lowest landing ball wins both the slot write and the report.
    always_comb begin
        pat_nxt    = pattern_out;
        filled_nxt = filled;
        pulse      = 1'b0;
        err_set    = 1'b0;
        rep_ball   = '0;
        rep_h      = '0;
        if (restart) begin
            filled_nxt = '0;
        end else begin
            for (int i = 6; i >= 0; i--) begin
                if (land_q[i]) begin
                    pat_nxt[land_slot_q[i]]    = land_h_q[i];
                    filled_nxt[land_slot_q[i]] = 1'b1;
                    pulse    = 1'b1;
                    rep_ball = 3'(i);
                    rep_h    = land_h_q[i];
                    if (land_sat_q[i]) err_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pattern_out       <= '0;
            filled            <= '0;
            pattern_valid_out <= 1'b0;
            throw_valid_out   <= 1'b0;
            throw_ball_out    <= '0;
            throw_height_out  <= '0;
            error_out         <= 1'b0;
        end else begin
            pattern_out       <= pat_nxt;
            filled            <= filled_nxt;
            pattern_valid_out <= &(filled_nxt | ~slot_mask);
            throw_valid_out   <= pulse;
            if (pulse) begin
                throw_ball_out   <= rep_ball;
                throw_height_out <= rep_h;
            end
            if (err_set) error_out <= 1'b1;
        end
    end

`ifdef SITESWAP_CHECK_EN
    logic [5:0] slot_sum, target;
    logic       conflict, wrote_q;

    assign target = 6'(num_balls) * 6'(per_eff);

    always_comb begin
        slot_sum = '0;
        conflict = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (slot_mask[k]) slot_sum = slot_sum + 6'(pattern_out[k]);
        end
        for (int i = 0; i < 7; i++) begin
            if (land_q[i] && filled[land_slot_q[i]] &&
                (pattern_out[land_slot_q[i]] != land_h_q[i])) conflict = 1'b1;
        end
    end

    // Sum is judged one cycle after a write, against the freshly updated slots.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mismatch_out <= 1'b0;
            wrote_q      <= 1'b0;
        end else begin
            wrote_q <= pulse;
            if ((conflict && !restart) ||
                (wrote_q && pattern_valid_out && (slot_sum != target))) mismatch_out <= 1'b1;
        end
    end
`else
    assign mismatch_out = 1'b0;
`endif

endmodule

// File: tb/tb_siteswap_decoder.sv
// Directed testbench for siteswap_decoder: scheduled ball flights, landing scoreboard, output checks.
module tb_siteswap_decoder;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [6:0][10:0] traj_x_in;
    logic [6:0][9:0]  traj_y_in;
    logic             traj_valid_in;
    logic [2:0]       num_balls;
    logic [2:0]       period_in;
    logic [9:0]       hand_y_in;
    logic [31:0]      cyc_per_beat;
    logic [6:0][2:0]  pattern_out;
    logic             pattern_valid_out;
    logic             throw_valid_out;
    logic [2:0]       throw_ball_out;
    logic [2:0]       throw_height_out;
    logic             error_out;
    logic             mismatch_out;
    logic [1:0]       fsm_state;

    always #5 clk_in = ~clk_in;

    siteswap_decoder #(.MAX_HEIGHT(7)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .traj_x_in         (traj_x_in),
        .traj_y_in         (traj_y_in),
        .traj_valid_in     (traj_valid_in),
        .num_balls         (num_balls),
        .period_in         (period_in),
        .hand_y_in         (hand_y_in),
        .cyc_per_beat      (cyc_per_beat),
        .pattern_out       (pattern_out),
        .pattern_valid_out (pattern_valid_out),
        .throw_valid_out   (throw_valid_out),
        .throw_ball_out    (throw_ball_out),
        .throw_height_out  (throw_height_out),
        .error_out         (error_out),
        .mismatch_out      (mismatch_out),
        .fsm_state         (fsm_state)
    );

`ifdef SITESWAP_CHECK_EN
    localparam logic CHECK_BUILD = 1'b1;
`else
    localparam logic CHECK_BUILD = 1'b0;
`endif

    typedef struct {
        int ball;
        int t0;
        int len;
    } flight_t;

    flight_t    sched[$];
    logic [5:0] exp_q[$];
    int         t;
    int         n_checks;
    int         n_fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_flight(input int b, input int t0, input int len);
        flight_t f;
        f.ball = b;
        f.t0   = t0;
        f.len  = len;
        sched.push_back(f);
    endtask

    task automatic expect_landing(input int b, input int h);
        exp_q.push_back({3'(b), 3'(h)});
    endtask

    // Parabolic arc strictly above the hand for the whole flight, at hand level otherwise.
    function automatic logic [9:0] ball_y(input int b, input int tt);
        int d;
        int p;
        ball_y = hand_y_in;
        foreach (sched[k]) begin
            if (sched[k].ball == b && tt >= sched[k].t0 && tt < sched[k].t0 + sched[k].len) begin
                d = tt - sched[k].t0;
                p = d * (sched[k].len - d);
                if (p > 300) p = 300;
                ball_y = hand_y_in - 10'(p + 1);
            end
        end
    endfunction

    task automatic step(input logic valid);
        logic [5:0] e;
        for (int i = 0; i < 7; i++) traj_y_in[i] = ball_y(i, t);
        traj_valid_in = valid;
        @(posedge clk_in);
        #1;
        if (valid) t++;
        if (throw_valid_out) begin
            chk("pulse_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse_ball", 32'(throw_ball_out), 32'(e[5:3]));
                chk("pulse_height", 32'(throw_height_out), 32'(e[2:0]));
            end
        end
    endtask

    task automatic run_until(input int t_end);
        while (t < t_end) step(1'b1);
    endtask

    task automatic apply_reset();
        rst_in        = 1'b0;
        traj_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        sched.delete();
        exp_q.delete();
        t = 0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 7; k++)
            chk($sformatf("%s_pattern%0d", tag, k), 32'(pattern_out[k]), 32'd0);
        chk({tag, "_pvalid"}, 32'(pattern_valid_out), 32'd0);
        chk({tag, "_tvalid"}, 32'(throw_valid_out), 32'd0);
        chk({tag, "_tball"}, 32'(throw_ball_out), 32'd0);
        chk({tag, "_theight"}, 32'(throw_height_out), 32'd0);
        chk({tag, "_error"}, 32'(error_out), 32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch_out), 32'd0);
        chk({tag, "_fsm"}, 32'(fsm_state), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        t             = 0;
        rst_in        = 1'b0;
        traj_x_in     = '0;
        traj_y_in     = '0;
        traj_valid_in = 1'b0;
        num_balls     = 3'd3;
        period_in     = 3'd3;
        hand_y_in     = 10'd400;
        cyc_per_beat  = 32'd4;

        apply_reset();
        check_reset_state("por");
        step(1'b0);
        chk("fsm_arm", 32'(fsm_state), 32'd1);

        // Cascade 3,3,3 at four samples per beat.
        add_flight(0, 2, 12);
        add_flight(1, 6, 12);
        add_flight(2, 10, 12);
        expect_landing(0, 3);
        expect_landing(1, 3);
        expect_landing(2, 3);
        run_until(1);
        chk("fsm_track", 32'(fsm_state), 32'd2);
        run_until(21);
        chk("casc_slot1", 32'(pattern_out[1]), 32'd3);
        chk("casc_slot2_empty", 32'(pattern_out[2]), 32'd0);
        chk("casc_pvalid_early", 32'(pattern_valid_out), 32'd0);
        run_until(26);
        chk("casc_slot0", 32'(pattern_out[0]), 32'd3);
        chk("casc_slot2", 32'(pattern_out[2]), 32'd3);
        chk("casc_pvalid", 32'(pattern_valid_out), 32'd1);
        chk("casc_mismatch", 32'(mismatch_out), 32'd0);
        chk("casc_drained", 32'(exp_q.size()), 32'd0);

        // Pattern 5,3,1 at eight samples per beat.
        apply_reset();
        cyc_per_beat = 32'd8;
        step(1'b0);
        add_flight(0, 2, 40);
        add_flight(1, 10, 24);
        add_flight(2, 18, 8);
        expect_landing(2, 1);
        expect_landing(1, 3);
        expect_landing(0, 5);
        run_until(46);
        chk("p531_slot0", 32'(pattern_out[0]), 32'd5);
        chk("p531_slot1", 32'(pattern_out[1]), 32'd3);
        chk("p531_slot2", 32'(pattern_out[2]), 32'd1);
        chk("p531_pvalid", 32'(pattern_valid_out), 32'd1);
        chk("p531_mismatch", 32'(mismatch_out), 32'd0);
        chk("p531_error", 32'(error_out), 32'd0);
        chk("p531_drained", 32'(exp_q.size()), 32'd0);

        // Rounding boundary and saturation.
        apply_reset();
        cyc_per_beat = 32'd4;
        step(1'b0);
        add_flight(0, 2, 13);
        add_flight(1, 3, 14);
        add_flight(2, 4, 40);
        expect_landing(0, 3);
        expect_landing(1, 4);
        expect_landing(2, 7);
        run_until(22);
        chk("round_13", 32'(pattern_out[0]), 32'd3);
        chk("round_14", 32'(pattern_out[1]), 32'd4);
        chk("round_error_clear", 32'(error_out), 32'd0);
        run_until(48);
        chk("sat_slot", 32'(pattern_out[2]), 32'd7);
        chk("sat_error", 32'(error_out), 32'd1);
        chk("sat_pvalid", 32'(pattern_valid_out), 32'd1);
        chk("sat_mismatch", 32'(mismatch_out), 32'(CHECK_BUILD));
        chk("sat_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a ball is airborne.
        add_flight(0, 50, 12);
        run_until(55);
        apply_reset();
        check_reset_state("mid_reset");

        // Same-cycle throws and landings.
        step(1'b0);
        add_flight(0, 2, 12);
        add_flight(2, 2, 12);
        add_flight(1, 5, 12);
        expect_landing(0, 3);
        expect_landing(1, 3);
        run_until(17);
        chk("simul_slot0", 32'(pattern_out[0]), 32'd3);
        chk("simul_slot1", 32'(pattern_out[1]), 32'd3);
        chk("simul_slot2_empty", 32'(pattern_out[2]), 32'd0);
        chk("simul_pvalid_early", 32'(pattern_valid_out), 32'd0);
        run_until(20);
        chk("simul_slot2", 32'(pattern_out[2]), 32'd3);
        chk("simul_pvalid", 32'(pattern_valid_out), 32'd1);
        chk("simul_drained", 32'(exp_q.size()), 32'd0);

        // Freeze mid-flight, then restart on a period change.
        apply_reset();
        step(1'b0);
        add_flight(0, 2, 12);
        add_flight(1, 3, 12);
        add_flight(2, 4, 12);
        expect_landing(0, 3);
        expect_landing(1, 3);
        expect_landing(2, 3);
        run_until(6);
        repeat (5) step(1'b0);
        run_until(20);
        chk("freeze_slot0", 32'(pattern_out[0]), 32'd3);
        chk("freeze_slot1", 32'(pattern_out[1]), 32'd3);
        chk("freeze_slot2", 32'(pattern_out[2]), 32'd3);
        chk("freeze_pvalid", 32'(pattern_valid_out), 32'd1);
        period_in = 3'd1;
        step(1'b0);
        chk("restart_fsm_arm", 32'(fsm_state), 32'd1);
        chk("restart_pvalid", 32'(pattern_valid_out), 32'd0);
        step(1'b1);
        chk("restart_fsm_track", 32'(fsm_state), 32'd2);
        add_flight(0, 23, 8);
        expect_landing(0, 2);
        run_until(34);
        chk("restart_slot0", 32'(pattern_out[0]), 32'd2);
        chk("restart_pvalid_again", 32'(pattern_valid_out), 32'd1);
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        // Conflicting height into an already-filled slot.
        apply_reset();
        step(1'b0);
        add_flight(0, 2, 12);
        add_flight(1, 20, 14);
        expect_landing(0, 3);
        expect_landing(1, 4);
        run_until(18);
        chk("inject_first", 32'(pattern_out[0]), 32'd3);
        chk("inject_pvalid", 32'(pattern_valid_out), 32'd1);
        chk("inject_mismatch_clear", 32'(mismatch_out), 32'd0);
        run_until(38);
        chk("inject_overwrite", 32'(pattern_out[0]), 32'd4);
        chk("inject_mismatch", 32'(mismatch_out), 32'(CHECK_BUILD));
        chk("inject_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
